yas_dispatch_ctrl: RTL and testbench

Packet dispatch controller between the router input interface and the three output channels.
- Accepts a byte stream on a req/ack interface.
- Decodes the header byte and matches its address against the three channel addresses from the config registers.
- Forwards the whole packet to the selected channel through a single output holding register, or silently consumes it when no channel matches.
- Sits in the top level between the input interface and the data_out/data_out_req/data_out_ack ports.

---
 rtl/yas_router_pkg.sv | 19 +
 rtl/yas_crc8.sv | 41 ++++
 rtl/yas_dispatch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_yas_dispatch_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yas_router_pkg.sv
// Shared types and constants for the router dispatch slice.
// FSM encoding, header field positions, CRC polynomial, channel count.
package yas_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DROP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 6;

  localparam logic [7:0] CRC_POLY = 8'h07;

  localparam int NUM_CH = 3;

endpackage

// File: rtl/yas_crc8.sv
// Byte-wide CRC-8 accumulator (MSB-first, init 0).
// clr with en restarts the sum from zero with the current byte.
module yas_crc8
  import yas_router_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  logic [7:0] seed;

  assign seed = clr ? 8'h00 : crc;

  // Accumulate one byte per enable, restarting on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(seed, data);
    end else if (clr) begin
      crc <= 8'h00;
    end
  end

endmodule

// File: rtl/yas_dispatch_ctrl.sv
// Packet dispatch: header decode, channel select, single holding register.
// Optional CRC trailer check under YAS_ROUTER_CRC_CHECK_EN.
module yas_dispatch_ctrl
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [1:0]            ch0_addr,
  input  logic [1:0]            ch1_addr,
  input  logic [1:0]            ch2_addr,
  input  logic                  crc_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]     out_req,
  input  logic [NUM_CH-1:0]     out_ack,
  output logic                  busy,
  output logic                  pkt_drop,
  output logic                  crc_err
);

  state_t state, state_nx;

  logic                  run;
  logic [1:0]            sel;
  logic [1:0]            hit_sel;
  logic                  hit;
  logic [1:0]            addr;
  logic [DATA_SIZE:0]    cnt;
  logic [DATA_SIZE:0]    cnt_ld;
  logic [DATA_WIDTH-1:0] obuf;
  logic                  ovalid;
  logic [NUM_CH-1:0]     sel_oh;
  logic                  sel_ack;
  logic                  beat;
  logic                  hdr_beat;
  logic                  body_beat;
  logic                  last_beat;
  logic                  trl_in;
  logic                  drop_q;

  assign addr     = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign sel_oh   = NUM_CH'(1) << sel;
  assign sel_ack  = |(out_ack & sel_oh);
  assign out_req  = ovalid ? sel_oh : '0;
  assign out_data = obuf;
  assign busy     = (state != ST_IDLE);
  assign pkt_drop = drop_q;

  assign beat      = in_req && in_ack;
  assign hdr_beat  = beat && (state == ST_IDLE);
  assign body_beat = beat &&
                     ((state == ST_FWD) ||
                      (state == ST_DROP));
  assign last_beat = body_beat &&
                     (cnt == (DATA_SIZE+1)'(1));

  assign cnt_ld = {1'b0, in_data[DATA_SIZE-1:0]}
                + {{DATA_SIZE{1'b0}}, trl_in};

  // Address match, lowest channel index wins
  always_comb begin
    hit     = 1'b1;
    hit_sel = 2'd0;
    if (addr == ch0_addr) begin
      hit_sel = 2'd0;
    end else if (addr == ch1_addr) begin
      hit_sel = 2'd1;
    end else if (addr == ch2_addr) begin
      hit_sel = 2'd2;
    end else begin
      hit = 1'b0;
    end
  end

  // Input accept per state; held low until reset has settled
  always_comb begin
    in_ack = 1'b0;
    unique case (state)
      ST_IDLE:  in_ack = run;
      ST_FWD:   in_ack = !ovalid || sel_ack;
      ST_DROP:  in_ack = 1'b1;
      ST_DRAIN: in_ack = 1'b0;
      default:  in_ack = 1'b0;
    endcase
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (hdr_beat) begin
          if (hit) begin
            state_nx = (cnt_ld != '0) ? ST_FWD : ST_DRAIN;
          end else begin
            state_nx = (cnt_ld != '0) ? ST_DROP : ST_IDLE;
          end
        end
      end
      ST_FWD: begin
        if (last_beat) state_nx = ST_DRAIN;
      end
      ST_DROP: begin
        if (last_beat) state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!ovalid || sel_ack) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Holding register, byte counter, drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      sel    <= 2'd0;
      cnt    <= '0;
      obuf   <= '0;
      ovalid <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      run    <= 1'b1;
      drop_q <= hdr_beat && !hit;
      if (hdr_beat) begin
        sel <= hit_sel;
        cnt <= cnt_ld;
        if (hit) begin
          obuf   <= in_data;
          ovalid <= 1'b1;
        end
      end else if (body_beat) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (state == ST_FWD) begin
          obuf   <= in_data;
          ovalid <= 1'b1;
        end
      end else if (ovalid && sel_ack) begin
        ovalid <= 1'b0;
      end
    end
  end

`ifdef YAS_ROUTER_CRC_CHECK_EN
  logic       trl_q;
  logic       trl_beat;
  logic       crc_upd;
  logic       crc_q;
  logic [7:0] crc_val;

  assign trl_in   = crc_en;
  assign trl_beat = last_beat && trl_q;
  assign crc_upd  = hdr_beat || (body_beat && !trl_beat);
  assign crc_err  = crc_q;

  yas_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hdr_beat),
    .en    (crc_upd),
    .data  (in_data[7:0]),
    .crc   (crc_val)
  );

  // Trailer mode latch and mismatch pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trl_q <= 1'b0;
      crc_q <= 1'b0;
    end else begin
      if (hdr_beat) trl_q <= crc_en;
      crc_q <= trl_beat && (in_data[7:0] != crc_val);
    end
  end
`else
  logic unused_crc_en;

  assign unused_crc_en = crc_en;
  assign trl_in        = 1'b0;
  assign crc_err       = 1'b0;
`endif

endmodule

// File: tb/tb_yas_dispatch_ctrl.sv
// Randomized bench for yas_dispatch_ctrl with a packet-level model.
// Directed cases plus random traffic; builds with or without CRC macro.
module tb_yas_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data;
  logic       in_req;
  logic       in_ack;
  logic [1:0] ch0_addr, ch1_addr, ch2_addr;
  logic       crc_en;
  logic [7:0] out_data;
  logic [2:0] out_req;
  logic [2:0] out_ack;
  logic       busy, pkt_drop, crc_err;

  always #5 clk = ~clk;

  yas_dispatch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .ch0_addr (ch0_addr),
    .ch1_addr (ch1_addr),
    .ch2_addr (ch2_addr),
    .crc_en   (crc_en),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .busy     (busy),
    .pkt_drop (pkt_drop),
    .crc_err  (crc_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  // stimulus controls
  logic [7:0] inq[$];
  bit         hold = 0;
  bit         chk_en = 0;
  int         gap_pct = 0;
  bit         ack_rand = 0;
  logic [2:0] ack_force = 3'b000;
  bit         cfg_rand = 0;

  // packet-level model
  logic [9:0] expq[$];
  int         m_rem = 0;
  int         m_ch = -1;
  bit         m_trl = 0;
  logic [7:0] m_crc = 0;
  bit         drop_exp = 0;
  bit         crc_exp = 0;
  int         n_req0, n_req1, n_drop, n_crcerr;

  // bit-serial CRC-8 over one byte, MSB first
  function automatic logic [7:0] crc_step(
    input logic [7:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic bit trl_mode();
`ifdef YAS_ROUTER_CRC_CHECK_EN
    return crc_en;
`else
    return 1'b0;
`endif
  endfunction

  task automatic consume(input logic [7:0] b);
    if (m_rem == 0) begin
      if (b[7:6] == ch0_addr) m_ch = 0;
      else if (b[7:6] == ch1_addr) m_ch = 1;
      else if (b[7:6] == ch2_addr) m_ch = 2;
      else m_ch = -1;
      m_trl = trl_mode();
      m_rem = int'(b[5:0]) + int'(m_trl);
      m_crc = crc_step(8'h00, b);
      if (m_ch < 0) drop_exp = 1;
    end else begin
      m_rem--;
      if (m_trl && m_rem == 0) begin
        if (b != m_crc) crc_exp = 1;
      end else begin
        m_crc = crc_step(m_crc, b);
      end
    end
    if (m_ch >= 0) expq.push_back({2'(m_ch), b});
  endtask

  task automatic sample();
    bit e_ack;
    chk("busy", busy,
        (m_rem != 0) || (expq.size() != 0));
    if (m_rem == 0) e_ack = (expq.size() == 0);
    else if (m_ch < 0) e_ack = 1;
    else e_ack = (expq.size() == 0) || out_ack[m_ch];
    chk("in_ack", in_ack, e_ack);
    if (expq.size() != 0) begin
      chk("out_req", out_req,
          3'b001 << expq[0][9:8]);
      chk("out_data", out_data, expq[0][7:0]);
    end else begin
      chk("out_req_idle", out_req, 0);
    end
    chk("pkt_drop", pkt_drop, drop_exp);
    chk("crc_err", crc_err, crc_exp);
    drop_exp = 0;
    crc_exp = 0;
    if (out_req == 3'b001) n_req0++;
    if (out_req == 3'b010) n_req1++;
    if (pkt_drop) n_drop++;
    if (crc_err) n_crcerr++;
    if (expq.size() != 0 && out_ack[expq[0][9:8]])
      void'(expq.pop_front());
    if (in_req && in_ack) begin
      consume(in_data);
      void'(inq.pop_front());
      hold = 0;
    end else begin
      hold = in_req;
    end
  endtask

  // per-cycle driver: drive at negedge, sample 1 before posedge
  always begin
    @(negedge clk);
    if (!hold) begin
      if (inq.size() != 0 && rst_n && chk_en &&
          $urandom_range(99) >= gap_pct) begin
        in_req = 1'b1;
        in_data = inq[0];
      end else begin
        in_req = 1'b0;
        in_data = 8'($urandom);
      end
    end
    out_ack = ack_rand ? 3'($urandom) : ack_force;
    if (cfg_rand && $urandom_range(15) == 0) begin
      ch0_addr = 2'($urandom);
      ch1_addr = 2'($urandom);
      ch2_addr = 2'($urandom);
    end
    #4;
    if (rst_n && chk_en) sample();
    else hold = 0;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((inq.size() != 0 || m_rem != 0 ||
            expq.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("idle_reached", n < budget, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic gen_pkt(input logic [7:0] hdr,
                         input bit bad);
    logic [7:0] c, b;
    inq.push_back(hdr);
    c = crc_step(8'h00, hdr);
    for (int i = 0; i < int'(hdr[5:0]); i++) begin
      b = 8'($urandom);
      inq.push_back(b);
      c = crc_step(c, b);
    end
    if (trl_mode())
      inq.push_back(bad ? (c ^ 8'h5A) : c);
  endtask

  task automatic set_cfg(input logic [1:0] a0,
                         input logic [1:0] a1,
                         input logic [1:0] a2);
    ch0_addr = a0;
    ch1_addr = a1;
    ch2_addr = a2;
  endtask

  initial begin
    int n;
    logic [7:0] c;
    in_req = 0;
    in_data = 0;
    out_ack = 0;
    crc_en = 0;
    set_cfg(0, 1, 2);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_drop", pkt_drop, 0);
    chk("rst_crc_err", crc_err, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1;

    // forward to ch1, ack held high
    ack_force = 3'b010;
    n_req1 = 0;
    inq.push_back(8'h43);
    inq.push_back(8'hAA);
    inq.push_back(8'hBB);
    inq.push_back(8'hCC);
    wait_idle(50);
    chk("d1_req_cycles", n_req1, 4);

    // unmatched header consumed
    n_drop = 0;
    inq.push_back(8'hC2);
    inq.push_back(8'h11);
    inq.push_back(8'h22);
    wait_idle(50);
    chk("d2_drop_pulses", n_drop, 1);

    // stall on ch0
    ack_force = 3'b000;
    inq.push_back(8'h02);
    inq.push_back(8'h5A);
    inq.push_back(8'h6B);
    n = 0;
    while (expq.size() == 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("d3_hdr_seen", n < 50, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("d3_hold_data", out_data, 8'h02);
    chk("d3_stall_ack", in_ack, 0);
    ack_force = 3'b001;
    wait_idle(50);

    // duplicate config, header-only
    set_cfg(2, 1, 2);
    ack_force = 3'b111;
    n_req0 = 0;
    inq.push_back(8'h80);
    wait_idle(50);
    chk("d4_req_ch0", n_req0, 1);
    set_cfg(0, 1, 2);

`ifdef YAS_ROUTER_CRC_CHECK_EN
    // good trailer then corrupt trailer
    crc_en = 1;
    n_crcerr = 0;
    c = crc_step(crc_step(8'h00, 8'h01), 8'h00);
    inq.push_back(8'h01);
    inq.push_back(8'h00);
    inq.push_back(c);
    inq.push_back(8'h01);
    inq.push_back(8'h00);
    inq.push_back(8'hFF);
    wait_idle(100);
    chk("d5_crc_pulses", n_crcerr, 1);
    crc_en = 0;
`endif

    // random traffic, both crc_en settings
    for (int ph = 0; ph < 2; ph++) begin
      crc_en = ph[0];
      cfg_rand = 1;
      ack_rand = 1;
      gap_pct = 30;
      gen_pkt({2'($urandom), 6'd63}, 0);
      for (int k = 0; k < 30; k++) begin
        c = {2'($urandom),
             ($urandom_range(9) == 0) ? 6'd63 :
             6'($urandom_range(5))};
        gen_pkt(c, $urandom_range(2) == 0);
      end
      wait_idle(5000);
      cfg_rand = 0;
    end
    crc_en = 0;

    // reset mid-forward
    set_cfg(0, 1, 2);
    ack_rand = 0;
    ack_force = 3'b111;
    gap_pct = 0;
    gen_pkt(8'h45, 0);
    n = 0;
    while (m_rem != 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("rst_mid_reach", m_rem, 3);
    #1;
    chk_en = 0;
    rst_n = 0;
    in_req = 0;
    hold = 0;
    #1;
    chk("mid_in_ack", in_ack, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_out_req", out_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pkt_drop", pkt_drop, 0);
    chk("mid_crc_err", crc_err, 0);
    inq.delete();
    expq.delete();
    m_rem = 0;
    drop_exp = 0;
    crc_exp = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1;
    n_req1 = 0;
    inq.push_back(8'h42);
    inq.push_back(8'h37);
    inq.push_back(8'h48);
    wait_idle(50);
    chk("post_rst_req", n_req1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
